// File: rtl/cotm32_pkg.sv
// Shared core-wide types and constants for the cotm32 core.
// Holds the data-memory map and the data-memory clear-sequencer state type.
package cotm32_pkg;

  localparam int XLEN       = 32;
  localparam int BYTE_WIDTH = 8;

  localparam logic [31:0] DATA_MEM_START = 32'h0001_0000;
  localparam logic [31:0] DATA_MEM_END   = 32'h0001_0FFF;

  localparam int DMEM_DEPTH_WORDS =
    int'((DATA_MEM_END - DATA_MEM_START + 32'd1) / 32'(XLEN / BYTE_WIDTH));

  typedef enum logic {
    S_CLEAR,
    S_READY
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment between a lane-0-justified port and a word-organised target:
// left-shifts write data and strobe into position, right-justifies read data.
module dmem_lane_align #(
  parameter int XLEN  = 32,
  parameter int LANES = XLEN / 8,
  parameter int OW    = $clog2(LANES)
) (
  input  logic [OW-1:0]    off,
  input  logic [XLEN-1:0]  wdata,
  input  logic [LANES-1:0] wstrb,
  input  logic [XLEN-1:0]  rword,
  output logic [XLEN-1:0]  wdata_al,
  output logic [LANES-1:0] strb_al,
  output logic [XLEN-1:0]  rdata
);

  // Byte offset scaled to a bit shift; lanes pushed past the top are dropped.
  logic [OW+2:0] shamt;
  assign shamt = {off, 3'b000};

  assign wdata_al = wdata << shamt;
  assign strb_al  = wstrb << off;
  assign rdata    = rword >> shamt;

endmodule

// File: rtl/dmem.sv
// Data memory behind the LSU: byte-lane writes, combinational right-justified reads,
// and a clear sequencer that zeroes the array after reset or on request.
module dmem
  import cotm32_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [XLEN-1:0]          i_addr,
  input  logic [XLEN-1:0]          i_wdata,
  input  logic [XLEN/BYTE_WIDTH-1:0] i_wstrb,
  input  logic                     i_we,
  input  logic                     i_clear,
  output logic [XLEN-1:0]          o_rdata,
  output logic                     o_ready,
  output logic                     o_oob
);

  localparam int NB = XLEN / BYTE_WIDTH;
  localparam logic [XLEN:0] OOB_LIMIT = (XLEN + 1)'(DEPTH_WORDS) << 2;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  dmem_state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic [XLEN-1:0] wdata_al;
  logic [NB-1:0]   strb_al;
  logic [XLEN-1:0] rdata_sh;
  logic            clr_we;
  logic            port_we;

  assign idx   = i_addr[AW+1:2];
  assign off   = i_addr[1:0];
  assign o_oob = ({1'b0, i_addr} >= OOB_LIMIT);

  dmem_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .off      (off),
    .wdata    (i_wdata),
    .wstrb    (i_wstrb),
    .rword    (mem[idx]),
    .wdata_al (wdata_al),
    .strb_al  (strb_al),
    .rdata    (rdata_sh)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The clear walks the array once and stops on the last word; i_clear is only honoured when ready.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_CLEAR: begin
        if (ptr_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = S_READY;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      S_READY: begin
        if (i_clear) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign o_ready = (state_q == S_READY);
  assign clr_we  = i_rst_n && (state_q == S_CLEAR);
  assign port_we = i_rst_n && i_we && o_ready && !o_oob;

  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[ptr_q] <= '0;
    end else if (port_we) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_al[b]) begin
          mem[idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_al[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign o_rdata = (o_ready && !o_oob) ? rdata_sh : '0;

endmodule

// File: tb/tb_dmem.sv
// Directed self-checking bench for dmem: clear sequencing, lane-aligned writes,
// right-justified reads, out-of-bounds suppression and reset during clear.
module tb_dmem;

  localparam int DEPTH = 1024;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        i_we;
  logic        i_clear;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_oob;

  int total;
  int bad;

  dmem #(
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .i_wstrb (i_wstrb),
    .i_we    (i_we),
    .i_clear (i_clear),
    .o_rdata (o_rdata),
    .o_ready (o_ready),
    .o_oob   (o_oob)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    i_addr  = addr;
    i_wdata = data;
    i_wstrb = strb;
    i_we    = 1'b1;
    tick();
    i_we    = 1'b0;
  endtask

  // Counts edges until o_ready rises, capped so a stuck sequencer cannot hang the run.
  task automatic count_until_ready(output int n);
    n = 0;
    while (!o_ready && n < DEPTH + 8) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    i_rst_n = 1'b0;
    i_addr  = 32'h20;
    tick();
    tick();
    #1;
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b want 0", o_ready);
    end
    total++;
    if (o_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_rdata: got %h want 00000000", o_rdata);
    end
    i_rst_n = 1'b1;
    n = 0;
    while (!o_ready && n < DEPTH + 8) begin
      if (n == 5) begin
        i_addr  = 32'h10;
        i_wdata = 32'hDEADBEEF;
        i_wstrb = 4'hF;
        i_we    = 1'b1;
      end else begin
        i_we = 1'b0;
      end
      tick();
      n++;
    end
    i_we = 1'b0;
    total++;
    if (n !== DEPTH) begin
      bad++;
      $display("[TB] FAIL reset_clear_len: got %0d want %0d", n, DEPTH);
    end
  endtask

  task automatic test_all_zero(input string tag);
    for (int w = 0; w < DEPTH; w++) begin
      i_addr = 32'(w * 4);
      #1;
      total++;
      if (o_rdata !== 32'h0) begin
        bad++;
        $display("[TB] FAIL %s_zero[%0d]: got %h want 00000000", tag, w, o_rdata);
      end
    end
  endtask

  task automatic test_dropped_write();
    i_addr = 32'h10;
    #1;
    total++;
    if (o_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL clear_write_dropped: got %h want 00000000", o_rdata);
    end
  endtask

  task automatic test_word();
    logic [31:0] exp [4];
    exp[0] = 32'h11223344;
    exp[1] = 32'h00112233;
    exp[2] = 32'h00001122;
    exp[3] = 32'h00000011;
    do_write(32'h20, 32'h11223344, 4'hF);
    for (int k = 0; k < 4; k++) begin
      i_addr = 32'h20 + 32'(k);
      #1;
      total++;
      if (o_rdata !== exp[k]) begin
        bad++;
        $display("[TB] FAIL word_read_off%0d: got %h want %h", k, o_rdata, exp[k]);
      end
    end
  endtask

  task automatic test_bytes();
    do_write(32'h31, 32'h000000AA, 4'h1);
    do_write(32'h33, 32'h000000BB, 4'h1);
    i_addr = 32'h30;
    #1;
    total++;
    if (o_rdata !== 32'hBB00AA00) begin
      bad++;
      $display("[TB] FAIL byte_writes: got %h want bb00aa00", o_rdata);
    end
    do_write(32'h32, 32'h0000CAFE, 4'h3);
    i_addr = 32'h30;
    #1;
    total++;
    if (o_rdata !== 32'hCAFEAA00) begin
      bad++;
      $display("[TB] FAIL half_write: got %h want cafeaa00", o_rdata);
    end
  endtask

  task automatic test_misaligned();
    do_write(32'h44, 32'h55667788, 4'hF);
    do_write(32'h43, 32'h00001234, 4'h3);
    i_addr = 32'h40;
    #1;
    total++;
    if (o_rdata !== 32'h34000000) begin
      bad++;
      $display("[TB] FAIL misaligned_lane3: got %h want 34000000", o_rdata);
    end
    i_addr = 32'h44;
    #1;
    total++;
    if (o_rdata !== 32'h55667788) begin
      bad++;
      $display("[TB] FAIL misaligned_next_word: got %h want 55667788", o_rdata);
    end
  endtask

  task automatic test_same_cycle();
    i_addr  = 32'h50;
    i_wdata = 32'hA5A5_5A5A;
    i_wstrb = 4'hF;
    i_we    = 1'b1;
    #1;
    total++;
    if (o_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL same_cycle_old: got %h want 00000000", o_rdata);
    end
    tick();
    i_we = 1'b0;
    #1;
    total++;
    if (o_rdata !== 32'hA5A5_5A5A) begin
      bad++;
      $display("[TB] FAIL same_cycle_new: got %h want a5a55a5a", o_rdata);
    end
  endtask

  task automatic test_oob();
    i_addr = 32'(DEPTH * 4 - 4);
    #1;
    total++;
    if (o_oob !== 1'b0) begin
      bad++;
      $display("[TB] FAIL oob_last_word: got %b want 0", o_oob);
    end
    i_addr = 32'(DEPTH * 4);
    #1;
    total++;
    if (o_oob !== 1'b1) begin
      bad++;
      $display("[TB] FAIL oob_flag: got %b want 1", o_oob);
    end
    total++;
    if (o_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oob_rdata: got %h want 00000000", o_rdata);
    end
    do_write(32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF);
    i_addr = 32'h0;
    #1;
    total++;
    if (o_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oob_write_suppressed: got %h want 00000000", o_rdata);
    end
  endtask

  task automatic test_clear();
    int n;
    // Port write in the clear cycle commits but gets wiped by the sweep.
    i_addr  = 32'h60;
    i_wdata = 32'h0BAD_F00D;
    i_wstrb = 4'hF;
    i_we    = 1'b1;
    i_clear = 1'b1;
    tick();
    i_we    = 1'b0;
    i_clear = 1'b0;
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_ready_drop: got %b want 0", o_ready);
    end
    count_until_ready(n);
    total++;
    if (n !== DEPTH) begin
      bad++;
      $display("[TB] FAIL clear_len: got %0d want %0d", n, DEPTH);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    do_write(32'h20, 32'h1357_9BDF, 4'hF);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    for (int k = 0; k < DEPTH / 2; k++) tick();
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midclear_ready: got %b want 0", o_ready);
    end
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    count_until_ready(n);
    total++;
    if (n !== DEPTH) begin
      bad++;
      $display("[TB] FAIL midclear_restart_len: got %0d want %0d", n, DEPTH);
    end
    i_addr = 32'h20;
    #1;
    total++;
    if (o_rdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL midclear_zero: got %h want 00000000", o_rdata);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    i_rst_n = 1'b0;
    i_addr  = '0;
    i_wdata = '0;
    i_wstrb = '0;
    i_we    = 1'b0;
    i_clear = 1'b0;

    test_reset();
    test_all_zero("reset");
    test_dropped_write();
    test_word();
    test_bytes();
    test_misaligned();
    test_same_cycle();
    test_oob();
    test_clear();
    test_all_zero("clear");
    test_reset_mid_clear();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
